// File: rtl/digger_pkg.sv
// Shared types and constants for the Digger monster blocks.
package digger_pkg;

    typedef enum logic [1:0] {
        SPAWN = 2'd0,
        ALIVE = 2'd1,
        DYING = 2'd2,
        DEAD  = 2'd3
    } monster_state_t;

    typedef logic [10:0] coord_t;

    localparam logic [7:0] SCORE_VALUE_DEF = 8'd250;

    // Animation index: elapsed dying frames / 4, pinned at the last bitmap.
    function automatic logic [3:0] dying_anim_idx(input logic [7:0] cnt);
        return (cnt[7:6] != 2'b00) ? 4'hF : cnt[5:2];
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Frame-interval counter with clear, enable and terminal-count compare.
// Latency: count updates one clock after en_i; tc_o is combinational on the stored count.
// Backpressure: none; clr_i has priority over en_i.
module frame_tick_counter (
    input  logic       clk,
    input  logic       resetN,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] term_i,
    output logic [7:0] cnt_d_o,
    output logic       tc_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_d_o = cnt_d;
    assign tc_o    = (cnt_q == term_i);

endmodule

// File: rtl/monster_life_ctrl.sv
// Monster life cycle: SPAWN -> ALIVE -> DYING -> DEAD (-> SPAWN when MONSTER_RESPAWN_EN is defined).
// Latency: all outputs registered; pulses appear the cycle after the advancing startOfFrame.
// Backpressure: none; game_active=0 freezes state and counters, hit latches still clear per frame.
module monster_life_ctrl
    import digger_pkg::*;
#(
    parameter logic [7:0] DYING_FRAMES   = 8'd16,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd120,
    parameter coord_t     SPAWN_X        = 11'd544,
    parameter coord_t     SPAWN_Y        = 11'd160,
    parameter logic [7:0] SCORE_VALUE    = SCORE_VALUE_DEF
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       game_active,
    input  logic       shotCollision,
    input  logic       playerCollision,
    output logic       monster_alive,
    output logic       monster_dying,
    output logic [3:0] dyingFrame,
    output logic       spawn_load,
    output coord_t     spawnX,
    output coord_t     spawnY,
    output logic       kill_pulse,
    output logic [7:0] scoreAdd,
    output logic       player_hit
);

    localparam logic [7:0] DYING_TERM   = DYING_FRAMES - 8'd1;
    localparam logic [7:0] RESPAWN_TERM = RESPAWN_FRAMES - 8'd1;

    monster_state_t state_q, state_d;
    logic           shot_l_q, shot_l_d;
    logic           player_l_q, player_l_d;
    logic           alive_q, dying_q, spawn_q, kill_q, phit_q;
    logic [3:0]     dframe_q, dframe_d;
    logic [7:0]     score_q;
    logic           spawn_d, kill_d, phit_d;
    logic           cnt_clr, cnt_en, cnt_tc;
    logic [7:0]     cnt_term, cnt_d;
    logic           tick;

    assign tick     = startOfFrame & game_active;
    assign cnt_term = (state_q == DEAD) ? RESPAWN_TERM : DYING_TERM;

    frame_tick_counter u_frame_cnt (
        .clk     (clk),
        .resetN  (resetN),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .term_i  (cnt_term),
        .cnt_d_o (cnt_d),
        .tc_o    (cnt_tc)
    );

    // Latches are evaluated on the frame strobe, then restart; a hit on the strobe cycle lands in the next frame.
    always_comb begin
        shot_l_d   = startOfFrame ? 1'b0 : shot_l_q;
        player_l_d = startOfFrame ? 1'b0 : player_l_q;
        if (game_active && (state_q == ALIVE)) begin
            if (shotCollision)   shot_l_d   = 1'b1;
            if (playerCollision) player_l_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        spawn_d = 1'b0;
        kill_d  = 1'b0;
        phit_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            SPAWN: begin
                if (tick) begin
                    state_d = ALIVE;
                    spawn_d = 1'b1;
                end
            end
            ALIVE: begin
                if (tick) begin
                    if (shot_l_q) begin
                        state_d = DYING;
                        kill_d  = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (player_l_q) begin
                        phit_d = 1'b1;
                    end
                end
            end
            DYING: begin
                if (tick) begin
                    if (cnt_tc) begin
                        state_d = DEAD;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            DEAD: begin
`ifdef MONSTER_RESPAWN_EN
                if (tick) begin
                    if (cnt_tc) begin
                        state_d = SPAWN;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
`endif
            end
            default: state_d = SPAWN;
        endcase
    end

    assign dframe_d = (state_d == DYING) ? dying_anim_idx(cnt_d) : 4'd0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= SPAWN;
            shot_l_q   <= 1'b0;
            player_l_q <= 1'b0;
            alive_q    <= 1'b0;
            dying_q    <= 1'b0;
            dframe_q   <= 4'd0;
            spawn_q    <= 1'b0;
            kill_q     <= 1'b0;
            score_q    <= 8'd0;
            phit_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shot_l_q   <= shot_l_d;
            player_l_q <= player_l_d;
            alive_q    <= (state_d == ALIVE);
            dying_q    <= (state_d == DYING);
            dframe_q   <= dframe_d;
            spawn_q    <= spawn_d;
            kill_q     <= kill_d;
            score_q    <= kill_d ? SCORE_VALUE : 8'd0;
            phit_q     <= phit_d;
        end
    end

    assign monster_alive = alive_q;
    assign monster_dying = dying_q;
    assign dyingFrame    = dframe_q;
    assign spawn_load    = spawn_q;
    assign kill_pulse    = kill_q;
    assign scoreAdd      = score_q;
    assign player_hit    = phit_q;
    assign spawnX        = SPAWN_X;
    assign spawnY        = SPAWN_Y;

endmodule

// File: tb/tb_monster_life_ctrl.sv
// Directed bench for monster_life_ctrl; respawn checks follow MONSTER_RESPAWN_EN.
module tb_monster_life_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        game_active = 1'b1;
    logic        shotCollision = 1'b0;
    logic        playerCollision = 1'b0;
    logic        monster_alive, monster_dying, spawn_load, kill_pulse, player_hit;
    logic [3:0]  dyingFrame;
    logic [10:0] spawnX, spawnY;
    logic [7:0]  scoreAdd;

    int n_cmp = 0;
    int n_bad = 0;
    int kill_seen = 0;
    int spawn_seen = 0;
    int phit_seen = 0;

    monster_life_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .startOfFrame    (startOfFrame),
        .game_active     (game_active),
        .shotCollision   (shotCollision),
        .playerCollision (playerCollision),
        .monster_alive   (monster_alive),
        .monster_dying   (monster_dying),
        .dyingFrame      (dyingFrame),
        .spawn_load      (spawn_load),
        .spawnX          (spawnX),
        .spawnY          (spawnY),
        .kill_pulse      (kill_pulse),
        .scoreAdd        (scoreAdd),
        .player_hit      (player_hit)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kill_pulse === 1'b1)  kill_seen++;
        if (spawn_load === 1'b1)  spawn_seen++;
        if (player_hit === 1'b1)  phit_seen++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe is high across exactly one rising edge; returns on the following negedge.
    task automatic frame_pulse(input logic shot_on_sof);
        @(negedge clk);
        startOfFrame  = 1'b1;
        shotCollision = shot_on_sof;
        @(negedge clk);
        startOfFrame  = 1'b0;
        shotCollision = 1'b0;
    endtask

    task automatic frame();
        idle(5);
        frame_pulse(1'b0);
    endtask

    task automatic hit(input logic shot, input logic plyr, input int n);
        @(negedge clk);
        shotCollision   = shot;
        playerCollision = plyr;
        idle(n);
        shotCollision   = 1'b0;
        playerCollision = 1'b0;
    endtask

    task automatic reset_and_spawn();
        @(negedge clk);
        resetN = 1'b0;
        idle(2);
        resetN = 1'b1;
        idle(2);
        frame_pulse(1'b0);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        idle(3);
        n_cmp++; if (monster_alive !== 1'b0) begin n_bad++; $display("FAIL reset_alive: got %b want 0", monster_alive); end
        n_cmp++; if (monster_dying !== 1'b0) begin n_bad++; $display("FAIL reset_dying: got %b want 0", monster_dying); end
        n_cmp++; if (dyingFrame !== 4'd0) begin n_bad++; $display("FAIL reset_dframe: got %0d want 0", dyingFrame); end
        n_cmp++; if ({spawn_load, kill_pulse, player_hit} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {spawn_load, kill_pulse, player_hit}); end
        n_cmp++; if (scoreAdd !== 8'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", scoreAdd); end
        n_cmp++; if (spawnX !== 11'd544) begin n_bad++; $display("FAIL spawnX: got %0d want 544", spawnX); end
        n_cmp++; if (spawnY !== 11'd160) begin n_bad++; $display("FAIL spawnY: got %0d want 160", spawnY); end
    endtask

    task automatic test_spawn();
        resetN = 1'b1;
        idle(4);
        n_cmp++; if (monster_alive !== 1'b0) begin n_bad++; $display("FAIL pre_sof_alive: got %b want 0", monster_alive); end
        frame_pulse(1'b0);
        n_cmp++; if (spawn_load !== 1'b1) begin n_bad++; $display("FAIL spawn_load: got %b want 1", spawn_load); end
        n_cmp++; if (monster_alive !== 1'b1) begin n_bad++; $display("FAIL spawn_alive: got %b want 1", monster_alive); end
        idle(1);
        n_cmp++; if (spawn_load !== 1'b0) begin n_bad++; $display("FAIL spawn_one_cycle: got %b want 0", spawn_load); end
    endtask

    task automatic test_kill_and_respawn();
        int k0;
        int s0;
        idle(3);
        hit(1'b1, 1'b0, 3);
        idle(2);
        k0 = kill_seen;
        frame_pulse(1'b0);
        n_cmp++; if (kill_pulse !== 1'b1) begin n_bad++; $display("FAIL kill_pulse: got %b want 1", kill_pulse); end
        n_cmp++; if (scoreAdd !== 8'd250) begin n_bad++; $display("FAIL kill_score: got %0d want 250", scoreAdd); end
        n_cmp++; if (monster_dying !== 1'b1 || monster_alive !== 1'b0) begin n_bad++; $display("FAIL kill_state: got dying=%b alive=%b want 1/0", monster_dying, monster_alive); end
        n_cmp++; if (dyingFrame !== 4'd0) begin n_bad++; $display("FAIL kill_dframe: got %0d want 0", dyingFrame); end
        idle(1);
        n_cmp++; if (kill_pulse !== 1'b0 || scoreAdd !== 8'd0) begin n_bad++; $display("FAIL kill_one_cycle: got %b/%0d want 0/0", kill_pulse, scoreAdd); end
        for (int f = 1; f <= 15; f++) begin
            frame();
            n_cmp++; if (dyingFrame !== 4'(f / 4) || monster_dying !== 1'b1) begin n_bad++; $display("FAIL dying_frame_%0d: got dframe=%0d dying=%b want %0d/1", f, dyingFrame, monster_dying, f / 4); end
        end
        frame();
        n_cmp++; if (monster_dying !== 1'b0 || dyingFrame !== 4'd0 || monster_alive !== 1'b0) begin n_bad++; $display("FAIL dead_at_16: got dying=%b dframe=%0d alive=%b want 0/0/0", monster_dying, dyingFrame, monster_alive); end
        n_cmp++; if (kill_seen - k0 !== 1) begin n_bad++; $display("FAIL single_kill: got %0d want 1", kill_seen - k0); end
        s0 = spawn_seen;
`ifdef MONSTER_RESPAWN_EN
        for (int f = 17; f <= 136; f++) frame();
        n_cmp++; if (spawn_seen - s0 !== 0) begin n_bad++; $display("FAIL early_respawn: got %0d want 0", spawn_seen - s0); end
        frame();
        n_cmp++; if (spawn_load !== 1'b1 || monster_alive !== 1'b1) begin n_bad++; $display("FAIL respawn_137: got load=%b alive=%b want 1/1", spawn_load, monster_alive); end
`else
        for (int f = 17; f <= 316; f++) frame();
        n_cmp++; if (spawn_seen - s0 !== 0 || monster_alive !== 1'b0) begin n_bad++; $display("FAIL no_respawn: got spawns=%0d alive=%b want 0/0", spawn_seen - s0, monster_alive); end
`endif
    endtask

    task automatic test_shot_priority();
        int p0;
        reset_and_spawn();
        idle(2);
        p0 = phit_seen;
        hit(1'b1, 1'b1, 2);
        frame();
        n_cmp++; if (kill_pulse !== 1'b1 || player_hit !== 1'b0) begin n_bad++; $display("FAIL both_hits: got kill=%b phit=%b want 1/0", kill_pulse, player_hit); end
        idle(2);
        n_cmp++; if (phit_seen - p0 !== 0) begin n_bad++; $display("FAIL both_no_phit: got %0d want 0", phit_seen - p0); end
    endtask

    task automatic test_player_hit();
        reset_and_spawn();
        hit(1'b0, 1'b1, 1);
        frame();
        n_cmp++; if (player_hit !== 1'b1 || monster_alive !== 1'b1 || kill_pulse !== 1'b0) begin n_bad++; $display("FAIL player_hit: got phit=%b alive=%b kill=%b want 1/1/0", player_hit, monster_alive, kill_pulse); end
        frame();
        n_cmp++; if (player_hit !== 1'b0) begin n_bad++; $display("FAIL phit_latch_clear: got %b want 0", player_hit); end
    endtask

    task automatic test_sof_collision();
        reset_and_spawn();
        idle(3);
        frame_pulse(1'b1);
        n_cmp++; if (kill_pulse !== 1'b0 || monster_alive !== 1'b1) begin n_bad++; $display("FAIL sof_hit_same_frame: got kill=%b alive=%b want 0/1", kill_pulse, monster_alive); end
        frame();
        n_cmp++; if (kill_pulse !== 1'b1) begin n_bad++; $display("FAIL sof_hit_next_frame: got %b want 1", kill_pulse); end
    endtask

    task automatic test_freeze_alive();
        int k0;
        int p0;
        reset_and_spawn();
        k0 = kill_seen;
        p0 = phit_seen;
        game_active = 1'b0;
        hit(1'b1, 1'b1, 2);
        frame();
        frame();
        n_cmp++; if (monster_alive !== 1'b1 || kill_seen != k0 || phit_seen != p0) begin n_bad++; $display("FAIL frozen_hit: got alive=%b kills=%0d phits=%0d want 1/0/0", monster_alive, kill_seen - k0, phit_seen - p0); end
        game_active = 1'b1;
        frame();
        n_cmp++; if (kill_pulse !== 1'b0 || player_hit !== 1'b0 || monster_alive !== 1'b1) begin n_bad++; $display("FAIL resume_stale: got kill=%b phit=%b alive=%b want 0/0/1", kill_pulse, player_hit, monster_alive); end
    endtask

    task automatic test_freeze_dying();
        int s0;
        reset_and_spawn();
        hit(1'b1, 1'b0, 1);
        frame();
        for (int f = 1; f <= 3; f++) frame();
        game_active = 1'b0;
        for (int f = 0; f < 10; f++) frame();
        n_cmp++; if (dyingFrame !== 4'd0 || monster_dying !== 1'b1) begin n_bad++; $display("FAIL frozen_dying: got dframe=%0d dying=%b want 0/1", dyingFrame, monster_dying); end
        game_active = 1'b1;
        frame();
        n_cmp++; if (dyingFrame !== 4'd1) begin n_bad++; $display("FAIL resume_dframe: got %0d want 1", dyingFrame); end
        for (int f = 5; f <= 15; f++) frame();
        n_cmp++; if (monster_dying !== 1'b1 || dyingFrame !== 4'd3) begin n_bad++; $display("FAIL shifted_15: got dying=%b dframe=%0d want 1/3", monster_dying, dyingFrame); end
        frame();
        n_cmp++; if (monster_dying !== 1'b0) begin n_bad++; $display("FAIL shifted_dead: got %b want 0", monster_dying); end
        s0 = spawn_seen;
`ifdef MONSTER_RESPAWN_EN
        for (int f = 17; f <= 136; f++) frame();
        n_cmp++; if (spawn_seen != s0) begin n_bad++; $display("FAIL shifted_early_spawn: got %0d want 0", spawn_seen - s0); end
        frame();
        n_cmp++; if (spawn_load !== 1'b1) begin n_bad++; $display("FAIL shifted_respawn: got %b want 1", spawn_load); end
`else
        for (int f = 17; f <= 150; f++) frame();
        n_cmp++; if (spawn_seen != s0) begin n_bad++; $display("FAIL shifted_no_spawn: got %0d want 0", spawn_seen - s0); end
`endif
    endtask

    task automatic test_reset_mid_dying();
        reset_and_spawn();
        hit(1'b1, 1'b0, 1);
        frame();
        for (int f = 1; f <= 5; f++) frame();
        idle(2);
        resetN = 1'b0;
        #1;
        n_cmp++; if ({monster_alive, monster_dying, spawn_load, kill_pulse, player_hit} !== 5'b0 || dyingFrame !== 4'd0 || scoreAdd !== 8'd0) begin n_bad++; $display("FAIL async_reset: got flags=%b dframe=%0d score=%0d want 0", {monster_alive, monster_dying, spawn_load, kill_pulse, player_hit}, dyingFrame, scoreAdd); end
        idle(2);
        resetN = 1'b1;
        idle(2);
        frame_pulse(1'b0);
        n_cmp++; if (spawn_load !== 1'b1 || monster_alive !== 1'b1 || monster_dying !== 1'b0) begin n_bad++; $display("FAIL reset_respawn: got load=%b alive=%b dying=%b want 1/1/0", spawn_load, monster_alive, monster_dying); end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_kill_and_respawn();
        test_shot_priority();
        test_player_hit();
        test_sof_collision();
        test_freeze_alive();
        test_freeze_dying();
        test_reset_mid_dying();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/monster_life_ctrl.md
# monster_life_ctrl

Life-cycle controller for one monster: the receiving end of the player-shot interface. It consumes per-pixel hit flags from the collision logic and the frame strobe, and sequences the monster through spawn, alive, dying animation and respawn wait. It emits a one-cycle kill pulse with a score value, a player-hit pulse, and the gating and animation signals used by the monster movement and bitmap blocks.

## Interface
Parameters:
- DYING_FRAMES, 8'd16: frames in the dying animation (1..255).
- RESPAWN_FRAMES, 8'd120: frames spent dead before respawn (1..255).
- SPAWN_X, 11'd544: spawn top-left X.
- SPAWN_Y, 11'd160: spawn top-left Y.
- SCORE_VALUE, 8'd250: points reported per kill.

Ports:
- clk  in  1  system clock; the only clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- game_active  in  1  0 freezes all state and counters.
- shotCollision  in  1  player shot overlaps monster this pixel.
- playerCollision  in  1  player overlaps monster this pixel.
- monster_alive  out  1  monster drawn and collidable.
- monster_dying  out  1  dying animation in progress.
- dyingFrame  out  4  animation index = elapsed dying frames >> 2, saturating at 15.
- spawn_load  out  1  one-cycle pulse; the movement block loads spawnX/spawnY.
- spawnX  out  11  equals SPAWN_X.
- spawnY  out  11  equals SPAWN_Y.
- kill_pulse  out  1  one-cycle pulse on kill.
- scoreAdd  out  8  SCORE_VALUE while kill_pulse=1, else 0.
- player_hit  out  1  one-cycle pulse when the live monster touches the player.

## Operation
- States are SPAWN, ALIVE, DYING and DEAD. The state machine advances only on cycles where startOfFrame=1 and game_active=1.
- Hit latching: shot_hit_l and player_hit_l set on any cycle the corresponding collision input is 1 and the state is ALIVE. Both latches clear on every startOfFrame cycle after they have been evaluated. Collisions outside ALIVE are ignored.
- SPAWN:
  - Next state is ALIVE.
  - spawn_load pulses.
- ALIVE:
  - If shot_hit_l: next state DYING, kill_pulse pulses, scoreAdd=SCORE_VALUE, frame counter cleared.
  - Else if player_hit_l: player_hit pulses and the state stays ALIVE.
  - If both latches are set in the same frame, the shot has priority: the monster dies and player_hit does not pulse.
- DYING:
  - Frame counter increments each frame.
  - When the counter reaches DYING_FRAMES-1: next state DEAD and counter cleared.
- DEAD:
  - Counter increments each frame.
  - When the counter reaches RESPAWN_FRAMES-1: next state SPAWN.
- Output decoding: monster_alive=1 only in ALIVE; monster_dying=1 only in DYING. dyingFrame holds 0 outside DYING.
- Frame counter is 8 bits, unsigned. It never wraps, because the terminal compare precedes the increment.
- game_active=0:
  - All counters and the state hold.
  - Latches still clear on startOfFrame, so no stale hit fires on resume.
  - Pulse outputs stay 0.
- Reset at any point aborts any animation or countdown.

## Timing
- Reset values:
  - State SPAWN, counter 0, latches 0.
  - monster_alive=0, monster_dying=0, dyingFrame=0.
  - spawn_load=0, kill_pulse=0, scoreAdd=0, player_hit=0.
  - spawnX/spawnY are constant.
- All outputs are registered.
- kill_pulse, scoreAdd, player_hit and spawn_load assert in the cycle after the startOfFrame cycle on which the transition is taken, for exactly one cycle.
- Latency from first reset release to monster_alive=1: first startOfFrame, plus 1 cycle.
- A collision arriving in the same cycle as startOfFrame is counted in the next frame.
- Kill to respawn: DYING_FRAMES + RESPAWN_FRAMES + 1 frames after the kill frame.

## Configuration
- Macro MONSTER_RESPAWN_EN.
- Defined: DEAD returns to SPAWN after RESPAWN_FRAMES, as described above.
- Undefined:
  - DEAD is terminal until resetN.
  - The initial post-reset SPAWN still occurs.
  - The DEAD countdown logic is omitted.

## Structure
- The shared package digger_pkg holds:
  - the monster_state_t enum (SPAWN, ALIVE, DYING, DEAD);
  - the 11-bit coordinate typedef;
  - the default SCORE_VALUE constant.
- One sub-module, frame_tick_counter:
  - 8-bit counter with clear, enable (startOfFrame & game_active) and terminal-count compare;
  - used for both the dying and respawn intervals.

## Test plan
- Reset, then one startOfFrame -> spawn_load pulses one cycle later; monster_alive=1 on that same cycle.
- shotCollision for 3 cycles mid-frame, then startOfFrame -> a single kill_pulse with scoreAdd=250, monster_dying=1, and dyingFrame steps 0,0,0,0,1,... per frame.
- After the kill, count frames -> DEAD after 16 frames; spawn_load again after 16+120+1 frames. Without MONSTER_RESPAWN_EN, no spawn_load within 300 frames.
- shotCollision and playerCollision in the same frame -> kill_pulse=1 and player_hit stays 0. playerCollision alone -> player_hit pulse, monster_alive stays 1.
- game_active=0 for 10 frames during DYING -> dyingFrame and the respawn time shift by exactly 10 frames. A collision while frozen produces no pulse.
- Assert resetN mid-DYING -> all outputs 0 immediately; the next startOfFrame respawns the monster.
